// File: rtl/reg_file.sv
// General-purpose register bank: WIDTH x DEPTH entries, one write port, two
// bypassed combinational read ports, optional hard-wired zero entry and a clear sweep.
module reg_file #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter bit ZERO_REG = 1'b0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             clr,
  output logic             busy,
  output logic [DEPTH-1:0] valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state_q;
  logic [AW-1:0]    idx_q;
  logic             busy_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic             wr_ok;

  // Writes are dropped outright while sweeping, so they never reach the bypass either.
  assign wr_ok = we && en && !busy_q && !(ZERO_REG && (waddr == '0));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          idx_q <= idx_q + AW'(1);
          if (idx_q == AW'(DEPTH - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    valid_d = valid_q;
    if (busy_q) begin
      valid_d[idx_q] = 1'b0;
    end else if (wr_ok) begin
      valid_d[waddr] = 1'b1;
    end
  end

  // NOTE: the storage array is reset on purpose -- the register bank must read
  // all-zero immediately on reset, so it cannot map to an unreset RAM macro.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (busy_q) begin
        mem_q[idx_q] <= '0;
      end else if (wr_ok) begin
        mem_q[waddr] <= wdata;
      end
    end
  end

  always_comb begin
    rdata_a = mem_q[raddr_a];
    if (ZERO_REG && (raddr_a == '0)) begin
      rdata_a = '0;
    end else if (wr_ok && (raddr_a == waddr)) begin
      rdata_a = wdata;
    end
  end

  always_comb begin
    rdata_b = mem_q[raddr_b];
    if (ZERO_REG && (raddr_b == '0)) begin
      rdata_b = '0;
    end else if (wr_ok && (raddr_b == waddr)) begin
      rdata_b = wdata;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: two instances (ZERO_REG off/on) driven in
// lockstep and compared against an array-based behavioural model.
module tb_reg_file;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          res;
  logic          en;
  logic          we;
  logic          clr;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr_a;
  logic [AW-1:0] raddr_b;
  logic [W-1:0]  wdata;
  logic [W-1:0]  ra0, rb0, raz, rbz;
  logic          busy0, busyz;
  logic [D-1:0]  valid0, validz;

  int checks   = 0;
  int failures = 0;

  reg_file #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1'b0)) dut0 (
    .clk(clk), .res(res), .en(en), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(ra0), .raddr_b(raddr_b), .rdata_b(rb0),
    .clr(clr), .busy(busy0), .valid(valid0)
  );

  reg_file #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1'b1)) dutz (
    .clk(clk), .res(res), .en(en), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(raz), .raddr_b(raddr_b), .rdata_b(rbz),
    .clr(clr), .busy(busyz), .valid(validz)
  );

  always #5 clk = ~clk;

  // Behavioural model: index 0 = plain bank, index 1 = bank with hard-wired zero entry.
  logic [W-1:0] m_mem   [2][D];
  logic [D-1:0] m_valid [2];
  bit           m_busy;
  int           m_idx;

  typedef struct {
    logic         we;
    logic         en;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [W-1:0]  ea0;
    logic [W-1:0]  eb0;
    logic [W-1:0]  eaz;
    logic [W-1:0]  ebz;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < D; i++) m_mem[z][i] = '0;
      m_valid[z] = '0;
    end
    m_busy = 1'b0;
    m_idx  = 0;
  endtask

  function automatic bit m_wr_ok(input int z);
    return we && en && !m_busy && !(z == 1 && waddr == 0);
  endfunction

  function automatic logic [W-1:0] m_read(input int z, input logic [AW-1:0] a);
    if (z == 1 && a == 0) return '0;
    if (m_wr_ok(z) && a == waddr) return wdata;
    return m_mem[z][a];
  endfunction

  // Advance the model by one clock with the current inputs, then cross the edge.
  task automatic step();
    for (int z = 0; z < 2; z++) begin
      if (m_busy) begin
        m_mem[z][m_idx]   = '0;
        m_valid[z][m_idx] = 1'b0;
      end else if (m_wr_ok(z)) begin
        m_mem[z][waddr]   = wdata;
        m_valid[z][waddr] = 1'b1;
      end
    end
    if (m_busy) begin
      if (m_idx == D - 1) begin
        m_busy = 1'b0;
        m_idx  = 0;
      end else begin
        m_idx++;
      end
    end else if (clr) begin
      m_busy = 1'b1;
      m_idx  = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, " rdata_a"},   ra0,    m_read(0, raddr_a));
    check({tag, " rdata_b"},   rb0,    m_read(0, raddr_b));
    check({tag, " z rdata_a"}, raz,    m_read(1, raddr_a));
    check({tag, " z rdata_b"}, rbz,    m_read(1, raddr_b));
    check({tag, " busy"},      busy0,  m_busy);
    check({tag, " z busy"},    busyz,  m_busy);
    check({tag, " valid"},     valid0, m_valid[0]);
    check({tag, " z valid"},   validz, m_valid[1]);
  endtask

  int cnt;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 3'd3, 8'hA5, 3'd3, 3'd1, 8'hA5, 8'h00, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 3'd3, 8'hA5, 3'd3, 3'd3, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    vecs[2] = '{1'b1, 1'b0, 3'd3, 8'h11, 3'd3, 3'd0, 8'hA5, 8'h00, 8'hA5, 8'h00};
    vecs[3] = '{1'b0, 1'b1, 3'd3, 8'h11, 3'd3, 3'd3, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    vecs[4] = '{1'b1, 1'b1, 3'd3, 8'h11, 3'd0, 3'd3, 8'h00, 8'h11, 8'h00, 8'h11};
    vecs[5] = '{1'b0, 1'b1, 3'd3, 8'h11, 3'd3, 3'd3, 8'h11, 8'h11, 8'h11, 8'h11};
    vecs[6] = '{1'b1, 1'b1, 3'd0, 8'hFF, 3'd0, 3'd3, 8'hFF, 8'h11, 8'h00, 8'h11};
    vecs[7] = '{1'b0, 1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, 8'hFF, 8'hFF, 8'h00, 8'h00};

    res = 1'b0; en = 1'b0; we = 1'b0; clr = 1'b0;
    waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy0, 1'b0);
    check("reset valid", valid0, 8'h00);
    check_all("reset");
    res = 1'b1;

    // Table-driven basic write / hold / bypass / zero-entry behaviour.
    for (int i = 0; i < 8; i++) begin
      we = vecs[i].we; en = vecs[i].en; waddr = vecs[i].wa; wdata = vecs[i].wd;
      raddr_a = vecs[i].ra; raddr_b = vecs[i].rb; clr = 1'b0;
      #1;
      check($sformatf("vec%0d rdata_a", i),   ra0, vecs[i].ea0);
      check($sformatf("vec%0d rdata_b", i),   rb0, vecs[i].eb0);
      check($sformatf("vec%0d z rdata_a", i), raz, vecs[i].eaz);
      check($sformatf("vec%0d z rdata_b", i), rbz, vecs[i].ebz);
      check_all("vec");
      step();
      if (i == 0) check("valid after first write", valid0, 8'h08);
    end
    check("table valid", valid0, 8'h09);
    check("table z valid", validz, 8'h08);

    // Fill every entry, then sweep with a dropped write and a re-pulse of clr.
    for (int i = 0; i < D; i++) begin
      we = 1'b1; en = 1'b1; waddr = AW'(i); wdata = 8'h11 * W'(i + 1);
      step();
    end
    we = 1'b0; clr = 1'b1; raddr_a = 3'd5; raddr_b = 3'd7;
    #1;
    check_all("pre-clear");
    step();
    clr = 1'b0;
    cnt = 0;
    while (busy0 && cnt < 20) begin
      if (cnt == 2) begin
        clr = 1'b1; we = 1'b1; waddr = 3'd7; wdata = 8'h77;
      end
      if (cnt == 4) begin
        clr = 1'b0; we = 1'b0;
      end
      #1;
      check($sformatf("sweep%0d entry5", cnt), ra0, (cnt >= 6) ? 32'h0 : 32'h66);
      check($sformatf("sweep%0d entry7", cnt), rb0, 32'h88);
      check_all("sweep");
      step();
      cnt++;
    end
    check("busy cycles", cnt, 8);
    for (int i = 0; i < D; i++) begin
      raddr_a = AW'(i); raddr_b = AW'(i);
      #1;
      check($sformatf("post-sweep entry%0d", i), ra0, 8'h00);
      check($sformatf("post-sweep z entry%0d", i), rbz, 8'h00);
    end
    check("post-sweep valid", valid0, 8'h00);
    check("post-sweep z valid", validz, 8'h00);
    we = 1'b1; waddr = 3'd7; wdata = 8'h77;
    step();
    we = 1'b0; raddr_a = 3'd7;
    #1;
    check("write after sweep", ra0, 8'h77);
    check("valid after sweep write", valid0, 8'h80);

    // Asynchronous reset in the middle of a sweep.
    we = 1'b1; waddr = 3'd2; wdata = 8'hC3;
    step();
    we = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    step();
    raddr_a = 3'd7; raddr_b = 3'd2;
    #2;
    res = 1'b0;
    #1;
    model_reset();
    check("midsweep reset busy", busy0, 1'b0);
    check("midsweep reset z busy", busyz, 1'b0);
    check("midsweep reset valid", valid0, 8'h00);
    check("midsweep reset entry7", ra0, 8'h00);
    check("midsweep reset entry2", rb0, 8'h00);
    check_all("midsweep reset");
    #1;
    res = 1'b1;
    we = 1'b1; en = 1'b1; waddr = 3'd2; wdata = 8'h5A;
    step();
    we = 1'b0;
    #1;
    check("write after reset", rb0, 8'h5A);
    check("valid after reset write", valid0, 8'h04);
    check_all("after reset");

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      en      = ($urandom_range(0, 3) != 0);
      we      = $urandom_range(0, 1);
      waddr   = AW'($urandom_range(0, D - 1));
      wdata   = W'($urandom);
      raddr_a = AW'($urandom_range(0, D - 1));
      raddr_b = AW'($urandom_range(0, D - 1));
      clr     = ($urandom_range(0, 31) == 0);
      #1;
      check_all("rand");
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
